// File: rtl/jk_pkg.sv
// jk_pkg: shared JK operation encoding and next-state function.
// Rev 1.0 - initial release.
`default_nettype none

package jk_pkg;

   // Encoded as {j,k}.
   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_e;

   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic w_d;
      case (jk_op_e'({j, k}))
         JK_HOLD:   w_d = q;
         JK_RESET:  w_d = 1'b0;
         JK_SET:    w_d = 1'b1;
         JK_TOGGLE: w_d = ~q;
         default:   w_d = (j & ~q) | (~k & q);
      endcase
      return w_d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/d_ff_sync.sv
// d_ff_sync: WIDTH-wide D register with synchronous active-high reset.
// Rev 1.0 - initial release.
`default_nettype none

module d_ff_sync #(
   parameter int                WIDTH       = 1,
   parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= RESET_VALUE;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/jk_ff_using_d.sv
// jk_ff_using_d: vectorised JK flip-flop built from a D register plus JK-to-D logic.
// Rev 1.0 - initial release. Optional simulation checks: define JK_ASSERT_EN.
`default_nettype none

module jk_ff_using_d
   import jk_pkg::*;
#(
   parameter int                WIDTH       = 1,
   parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
);

   logic [WIDTH-1:0] w_d;

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      assign w_d[g] = jk_next(q[g], j[g], k[g]);
   end

   d_ff_sync #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_dff (
      .clk (clk),
      .rst (rst),
      .i_d (w_d),
      .o_q (q)
   );

   assign qb = ~q;

`ifdef JK_ASSERT_EN
   logic             r_seen_rst;
   logic             r_exp_vld;
   logic [WIDTH-1:0] r_exp;

   // Expected q is captured at one edge and compared at the following one.
   always @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (qb[i] !== ~q[i])
            $error("jk_ff_using_d lane %0d t=%0t: qb=%b q=%b", i, $time, qb[i], q[i]);
         if (r_exp_vld && (q[i] !== r_exp[i]))
            $error("jk_ff_using_d lane %0d t=%0t: q=%b expected %b", i, $time, q[i], r_exp[i]);
         if (!rst && r_seen_rst && $isunknown({j[i], k[i]}))
            $error("jk_ff_using_d lane %0d t=%0t: j=%b k=%b unknown", i, $time, j[i], k[i]);
      end
      if (rst) begin
         r_seen_rst <= 1'b1;
         r_exp_vld  <= 1'b0;
      end else begin
         r_exp_vld  <= (r_seen_rst === 1'b1);
         for (int i = 0; i < WIDTH; i++) begin
            r_exp[i] <= jk_next(q[i], j[i], k[i]);
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_jk_ff_using_d.sv
// tb_jk_ff_using_d: directed-vector bench for single-lane and four-lane JK flip-flops.
// Rev 1.0 - initial release.
`default_nettype none

module tb_jk_ff_using_d;

   logic       clk = 1'b0;
   logic       rst;
   logic       j1, k1, q1, qb1;
   logic [3:0] j4, k4, q4, qb4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jk_ff_using_d #(.WIDTH(1)) u_dut1 (
      .j(j1), .k(k1), .clk(clk), .rst(rst), .q(q1), .qb(qb1)
   );

   jk_ff_using_d #(.WIDTH(4)) u_dut4 (
      .j(j4), .k(k4), .clk(clk), .rst(rst), .q(q4), .qb(qb4)
   );

   task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; j1 = 1'b0; k1 = 1'b0; j4 = 4'b0; k4 = 4'b0;
      tick();
      chk("rst_q",   {3'b0, q1},  4'b0000);
      chk("rst_qb",  {3'b0, qb1}, 4'b0001);
      chk("rst_q4",  q4,  4'b0000);
      chk("rst_qb4", qb4, 4'b1111);
      rst = 1'b0;
      tick();
      chk("hold0", {3'b0, q1}, 4'b0000);

      j1 = 1'b1; k1 = 1'b0;
      tick();
      chk("set_q",  {3'b0, q1},  4'b0001);
      chk("set_qb", {3'b0, qb1}, 4'b0000);
      j1 = 1'b0;
      tick();
      chk("hold1a", {3'b0, q1}, 4'b0001);
      tick();
      chk("hold1b", {3'b0, q1}, 4'b0001);

      k1 = 1'b1;
      tick();
      chk("reset_op",  {3'b0, q1}, 4'b0000);
      tick();
      chk("reset_op2", {3'b0, q1}, 4'b0000);

      j1 = 1'b1; k1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tog_q",  {3'b0, q1},  (i % 2 == 0) ? 4'b0001 : 4'b0000);
         chk("tog_qb", {3'b0, qb1}, (i % 2 == 0) ? 4'b0000 : 4'b0001);
      end

      j1 = 1'b1; k1 = 1'b0;
      tick();
      chk("pre_rst_set", {3'b0, q1}, 4'b0001);
      rst = 1'b1;
      #1;
      chk("rst_not_async", {3'b0, q1}, 4'b0001);
      tick();
      chk("rst_prio", {3'b0, q1}, 4'b0000);
      j1 = 1'b1; k1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_prio_tog", {3'b0, q1}, 4'b0000);
      end
      rst = 1'b0; j1 = 1'b0; k1 = 1'b0;
      tick();
      chk("post_rst_hold", {3'b0, q1}, 4'b0000);

      // Lanes 3..0: set, reset, toggle, hold.
      chk("ml_start", q4, 4'b0000);
      j4 = 4'b1010; k4 = 4'b0110;
      tick();
      chk("ml_edge1", q4,  4'b1010);
      chk("ml_qb1",   qb4, 4'b0101);
      tick();
      chk("ml_edge2", q4,  4'b1000);
      chk("ml_qb2",   qb4, 4'b0111);
      tick();
      chk("ml_edge3", q4,  4'b1010);
      j4 = 4'b0101; k4 = 4'b0101;
      tick();
      chk("ml_edge4", q4,  4'b1111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
